// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - time-set front end: 1 Hz divider, button debounce, set/auto-repeat FSM.
module clock_set_controller #(
  parameter int TICK_DIV        = 32768,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int HOLD_CYCLES     = 16384,
  parameter int REPEAT_DIV      = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn_hours,
  input  logic btn_minutes,
  output logic tick_1hz,
  output logic set_hours,
  output logic set_minutes,
  output logic set_tick
);

  localparam int TW = (TICK_DIV > 1)        ? $clog2(TICK_DIV)        : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int RW = (REPEAT_DIV > 1)      ? $clog2(REPEAT_DIV)      : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SET_HOURS,
    REPEAT_HOURS,
    SET_MINUTES,
    REPEAT_MINUTES
  } state_t;

  state_t state;

  // Index 0 is the hours button, index 1 the minutes button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    deb_state;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    accept;
  logic [1:0]    press;
  logic [1:0]    release_ev;

  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  logic own_rel;
  logic own_held;

  assign btn_raw = {btn_minutes, btn_hours};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // A change is accepted on the cycle the mismatch run reaches its terminal count.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = en && (sync_b[i] != deb_state[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  assign press      = accept & sync_b;
  assign release_ev = accept & ~sync_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_state <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != deb_state[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_state[i] <= sync_b[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end else if (en) begin
      tick_1hz <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end else begin
      tick_1hz <= 1'b0;
    end
  end

  // Only the button that started the sequence can end or sustain it.
  always_comb begin
    own_rel  = 1'b0;
    own_held = 1'b0;
    case (state)
      SET_HOURS, REPEAT_HOURS: begin
        own_rel  = release_ev[0];
        own_held = deb_state[0];
      end
      SET_MINUTES, REPEAT_MINUTES: begin
        own_rel  = release_ev[1];
        own_held = deb_state[1];
      end
      default: begin
        own_rel  = 1'b0;
        own_held = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      set_hours   <= 1'b0;
      set_minutes <= 1'b0;
      set_tick    <= 1'b0;
    end else if (!en) begin
      set_tick <= 1'b0;
    end else begin
      set_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (press[0]) begin
            state     <= SET_HOURS;
            set_hours <= 1'b1;
            set_tick  <= 1'b1;
            hold_cnt  <= '0;
          end else if (press[1]) begin
            state       <= SET_MINUTES;
            set_minutes <= 1'b1;
            set_tick    <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        SET_HOURS, SET_MINUTES: begin
          if (own_rel) begin
            state       <= IDLE;
            set_hours   <= 1'b0;
            set_minutes <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            if (own_held) begin
              state   <= (state == SET_HOURS) ? REPEAT_HOURS : REPEAT_MINUTES;
              rep_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        REPEAT_HOURS, REPEAT_MINUTES: begin
          if (own_rel) begin
            state       <= IDLE;
            set_hours   <= 1'b0;
            set_minutes <= 1'b0;
          end else if (rep_cnt == REP_LAST) begin
            set_tick <= 1'b1;
            rep_cnt  <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          set_hours   <= 1'b0;
          set_minutes <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 32768, meaning clk cycles per 1 Hz tick.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 256, meaning the consecutive stable samples needed to accept a button change.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16384, meaning the delay from accepted press to start of auto-repeat.
REQ-004 SHALL have parameter REPEAT_DIV, default 4096, meaning clk cycles between auto-repeat set pulses.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: global enable; when low, all counters and the FSM freeze and all pulse outputs are 0.
REQ-008 SHALL have port btn_hours, input, 1 bit: raw asynchronous hours-set button, active-high.
REQ-009 SHALL have port btn_minutes, input, 1 bit: raw asynchronous minutes-set button, active-high.
REQ-010 SHALL have port tick_1hz, output, 1 bit: one-cycle pulse once per TICK_DIV cycles; drives the time register enable.
REQ-011 SHALL have port set_hours, output, 1 bit: level, high while in SET_HOURS or REPEAT_HOURS.
REQ-012 SHALL have port set_minutes, output, 1 bit: level, high while in SET_MINUTES or REPEAT_MINUTES.
REQ-013 SHALL have port set_tick, output, 1 bit: one-cycle increment pulse for the field being set.

Function
REQ-014 SHALL synchronise each button through a 2-flop synchroniser before debouncing.
REQ-015 SHALL accept a change of debounced button state only after the synchronised input differs from the current debounced state for DEBOUNCE_CYCLES consecutive enabled cycles; any mismatch-free cycle in between clears that counter.
REQ-016 SHALL generate the tick divider as a counter 0..TICK_DIV-1 that wraps to 0 and pulses tick_1hz in the cycle where the count equals TICK_DIV-1.
REQ-017 SHALL keep tick_1hz running in every FSM state.
REQ-018 SHALL implement FSM states IDLE, SET_HOURS, REPEAT_HOURS, SET_MINUTES and REPEAT_MINUTES.
REQ-019 SHALL, in IDLE on an accepted hours press, go to SET_HOURS; else on an accepted minutes press, go to SET_MINUTES; a simultaneous press gives hours priority.
REQ-020 SHALL pulse set_tick exactly once, in the first cycle of SET_x, then start a hold counter at 0.
REQ-021 SHALL move SET_x to REPEAT_x when the hold counter reaches HOLD_CYCLES-1 with the button still held; the repeat counter starts at 0.
REQ-022 SHALL, in REPEAT_x, pulse set_tick when the repeat counter equals REPEAT_DIV-1, then wrap the counter to 0.
REQ-023 SHALL return any SET_x or REPEAT_x state to IDLE on debounced release of its own button, with no set_tick in the release cycle.
REQ-024 SHALL ignore the other button while in a set or repeat state; if it is still held on return to IDLE, its press SHALL NOT be accepted until it is released and pressed again.
REQ-025 SHALL not assert set_hours and set_minutes simultaneously.
REQ-026 SHALL size all counters as clog2 of their parameter, with a minimum of 1 bit; no counter may overflow past its terminal value.
REQ-027 SHALL register all outputs, giving a latency of 1 cycle from the state or count condition to the output.

Reset
REQ-028 SHALL, on reset, set the FSM to IDLE, all counters to 0, synchroniser and debounced states to 0, and outputs tick_1hz, set_hours, set_minutes and set_tick to 0 in the following cycle.
REQ-029 SHALL give reset priority over en; a reset asserted mid-set-sequence SHALL abort it with no further set_tick.
REQ-030 SHALL, after reset, emit the first tick_1hz TICK_DIV cycles after the first enabled cycle.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_DIV=3)
REQ-031 SHALL verify: en=1, no buttons for 35 cycles -> exactly 3 tick_1hz pulses, spaced 10 cycles apart.
REQ-032 SHALL verify: btn_hours high for 3 cycles then low -> no state change and set_tick stays 0 (debounce reject).
REQ-033 SHALL verify: btn_hours held for 30 cycles -> set_hours rises; one set_tick; after 8 cycles, set_tick every 3 cycles; set_minutes stays 0 throughout.
REQ-034 SHALL verify: both buttons pressed in the same cycle -> SET_HOURS only; after hours released with minutes still held -> IDLE, with no minutes setting until minutes is re-pressed.
REQ-035 SHALL verify: reset asserted during REPEAT_MINUTES -> all outputs 0 next cycle; FSM in IDLE; divider restarts from 0.
REQ-036 SHALL verify: en=0 for 20 cycles mid-count -> no pulses; counters resume from their held values when en returns high.
